// File: rtl/pmd901_spi_master.sv
// pmd901_spi_master: SPI mode-0 transmitter for the PMD901 motor driver.
// Accepts 16-bit speed words on a valid/ready handshake and shifts each one
// out MSB-first as a single csn-framed SPI transfer. park/bend only follow
// their request inputs between frames. fault/ready are 2-flop synchronized.
//
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   tx_data/valid/ready speed-word handshake
//   park_req, bend_req  requested pin states (sampled between frames)
//   csn, spi_clk, mosi  SPI pins (all registered)
//   park, bend          device control pins (registered)
//   fault, ready        async device status inputs
//   fault_sync, ready_sync  synchronized status
//   busy                transfer or inter-frame gap in progress
module pmd901_spi_master #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CSN_GAP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic        park_req,
    input  logic        bend_req,
    output logic        csn,
    output logic        spi_clk,
    output logic        mosi,
    output logic        park,
    output logic        bend,
    input  logic        fault,
    input  logic        ready,
    output logic        fault_sync,
    output logic        ready_sync,
    output logic        busy
);

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

    localparam logic [7:0] HalfLast = 8'(CLK_DIV - 1);
    localparam logic [7:0] GapLast  = 8'(CSN_GAP - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  fall_q, fall_d;     // falling edges already produced
    // mosi_q holds the current bit; shreg_q holds the bits still to come.
    logic [14:0] shreg_q, shreg_d;
    logic        csn_q, csn_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        park_q, park_d;
    logic        bend_q, bend_d;
    logic        fault_meta_q, fault_sync_q;
    logic        ready_meta_q, ready_sync_q;
    logic        hs;
    logic        cnt_half;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            fall_q       <= '0;
            shreg_q      <= '0;
            csn_q        <= 1'b1;
            sclk_q       <= 1'b0;
            mosi_q       <= 1'b0;
            park_q       <= 1'b0;
            bend_q       <= 1'b0;
            fault_meta_q <= 1'b0;
            fault_sync_q <= 1'b0;
            ready_meta_q <= 1'b0;
            ready_sync_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fall_q       <= fall_d;
            shreg_q      <= shreg_d;
            csn_q        <= csn_d;
            sclk_q       <= sclk_d;
            mosi_q       <= mosi_d;
            park_q       <= park_d;
            bend_q       <= bend_d;
            fault_meta_q <= fault;
            fault_sync_q <= fault_meta_q;
            ready_meta_q <= ready;
            ready_sync_q <= ready_meta_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fall_d   = fall_q;
        shreg_d  = shreg_q;
        csn_d    = csn_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        park_d   = park_q;
        bend_d   = bend_q;
        tx_ready = (state_q == StIdle) && park_q && ready_sync_q && !fault_sync_q;
        hs       = tx_valid && tx_ready;
        cnt_half = (cnt_q == HalfLast);

        unique case (state_q)
            StIdle: begin
                if (hs) begin
                    shreg_d = tx_data[14:0];
                    mosi_d  = tx_data[15];
                    csn_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StSetup;
                end else begin
                    park_d = park_req;
                    bend_d = bend_req;
                end
            end
            StSetup: begin
                if (cnt_half) begin
                    cnt_d   = '0;
                    fall_d  = '0;
                    sclk_d  = 1'b1;
                    state_d = StShift;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StShift: begin
                if (cnt_half) begin
                    cnt_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        if (fall_q == 4'd15) begin
                            // Last bit stays on mosi through HOLD.
                            state_d = StHold;
                        end else begin
                            fall_d  = fall_q + 4'd1;
                            mosi_d  = shreg_q[14];
                            shreg_d = {shreg_q[13:0], 1'b0};
                        end
                    end else begin
                        sclk_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StHold: begin
                if (cnt_half) begin
                    cnt_d   = '0;
                    csn_d   = 1'b1;
                    mosi_d  = 1'b0;
                    state_d = StGap;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StGap: begin
                park_d = park_req;
                bend_d = bend_req;
                if (cnt_q == GapLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign csn        = csn_q;
    assign spi_clk    = sclk_q;
    assign mosi       = mosi_q;
    assign park       = park_q;
    assign bend       = bend_q;
    assign fault_sync = fault_sync_q;
    assign ready_sync = ready_sync_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_pmd901_spi_master.sv
// Self-checking bench for pmd901_spi_master. A cycle-level reference model
// derives every pin value from the handshake cycle using the frame timing
// formulas; a pin monitor rebuilds each word from rising spi_clk edges.
module tb_pmd901_spi_master;

    localparam int unsigned H = 4;
    localparam int unsigned G = 4;
    localparam int FrameEnd = 1 + 33 * H;   // csn rises this many cycles after handshake

    logic        clk;
    logic        rst_n;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        park_req;
    logic        bend_req;
    logic        csn;
    logic        spi_clk;
    logic        mosi;
    logic        park;
    logic        bend;
    logic        fault;
    logic        ready;
    logic        fault_sync;
    logic        ready_sync;
    logic        busy;

    pmd901_spi_master #(
        .CLK_DIV(H),
        .CSN_GAP(G)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .park_req  (park_req),
        .bend_req  (bend_req),
        .csn       (csn),
        .spi_clk   (spi_clk),
        .mosi      (mosi),
        .park      (park),
        .bend      (bend),
        .fault     (fault),
        .ready     (ready),
        .fault_sync(fault_sync),
        .ready_sync(ready_sync),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Reference model state
    bit          model_en = 0;
    bit          have_frame;
    int          t0;
    logic [15:0] word_m;
    bit          park_m, bend_m, f1_m, fs_m, r1_m, rs_m;
    int          hs_cnt = 0;
    logic [15:0] exp_q[$];

    // Pin monitor state
    bit          prev_csn, prev_sclk, prev_park, prev_bend;
    logic [15:0] cap;
    int          edges;
    int          csn_rise_cyc;
    bit          b2b_arm;
    bit          rand_bend = 0;

    task automatic model_reset();
        have_frame = 0;
        park_m = 0; bend_m = 0;
        f1_m = 0; fs_m = 0; r1_m = 0; rs_m = 0;
        exp_q.delete();
        prev_csn = 1; prev_sclk = 0; prev_park = 0; prev_bend = 0;
        cap = '0; edges = 0; csn_rise_cyc = cyc; b2b_arm = 0;
    endtask

    always @(negedge clk) begin
        int n, j, idx;
        bit in_csn, in_gap, idle, exp_rdy, exp_sclk, exp_mosi;
        if (model_en) begin
            n       = have_frame ? (cyc - t0) : 1 << 20;
            in_csn  = have_frame && n >= 1 && n < FrameEnd;
            in_gap  = have_frame && n >= FrameEnd && n < FrameEnd + G;
            idle    = !in_csn && !in_gap;
            exp_rdy = idle && park_m && rs_m && !fs_m;
            exp_sclk = in_csn && n >= 1 + H && n < 1 + 32 * H && (((n - 1) / H) % 2 == 1);
            j   = in_csn ? (n - 1) / (2 * H) : 0;
            idx = (j > 15) ? 0 : 15 - j;
            exp_mosi = in_csn ? word_m[idx] : 1'b0;

            check_eq("csn",        32'(csn),        32'(!in_csn));
            check_eq("spi_clk",    32'(spi_clk),    32'(exp_sclk));
            check_eq("mosi",       32'(mosi),       32'(exp_mosi));
            check_eq("park",       32'(park),       32'(park_m));
            check_eq("bend",       32'(bend),       32'(bend_m));
            check_eq("tx_ready",   32'(tx_ready),   32'(exp_rdy));
            check_eq("busy",       32'(busy),       32'(in_csn || in_gap));
            check_eq("fault_sync", 32'(fault_sync), 32'(fs_m));
            check_eq("ready_sync", 32'(ready_sync), 32'(rs_m));

            // Pin-level monitor
            if (!csn && prev_csn) begin
                edges = 0;
                cap   = '0;
                if (b2b_arm) check_eq("b2b_csn_high", 32'(cyc - csn_rise_cyc), 32'(G + 1));
            end
            if (!csn && spi_clk && !prev_sclk) begin
                cap = {cap[14:0], mosi};
                edges++;
            end
            if (!csn && !prev_csn) begin
                check_eq("park_hold", 32'(park), 32'(prev_park));
                check_eq("bend_hold", 32'(bend), 32'(prev_bend));
            end
            if (csn && !prev_csn) begin
                csn_rise_cyc = cyc;
                check_eq("rise_edges", 32'(edges), 32'd16);
                check_eq("frame_queued", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) check_eq("capture", 32'(cap), 32'(exp_q.pop_front()));
            end
            prev_csn  = csn;
            prev_sclk = spi_clk;
            prev_park = park;
            prev_bend = bend;

            // Advance model across the coming clock edge
            if (tx_valid && exp_rdy) begin
                t0 = cyc;
                have_frame = 1;
                word_m = tx_data;
                exp_q.push_back(tx_data);
                hs_cnt++;
            end else if (idle || in_gap) begin
                park_m = park_req;
                bend_m = bend_req;
            end
            fs_m = f1_m; f1_m = fault;
            rs_m = r1_m; r1_m = ready;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_bend) bend_req = 1'($urandom_range(0, 1));
        end
    endtask

    // Present a word with tx_valid held; returns just after the accepting edge.
    task automatic send(input logic [15:0] w);
        int start;
        bit done;
        start    = hs_cnt;
        tx_data  = w;
        tx_valid = 1'b1;
        done     = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            tick(1);
            if (hs_cnt != start) done = 1;
        end
        check_eq("handshake", 32'(done), 32'd1);
    endtask

    initial begin
        int hi;
        int hs_before;
        rst_n = 0; tx_valid = 0; tx_data = '0;
        park_req = 1; bend_req = 0; fault = 0; ready = 1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_csn",        32'(csn),        32'd1);
        check_eq("rst_spi_clk",    32'(spi_clk),    32'd0);
        check_eq("rst_mosi",       32'(mosi),       32'd0);
        check_eq("rst_park",       32'(park),       32'd0);
        check_eq("rst_bend",       32'(bend),       32'd0);
        check_eq("rst_tx_ready",   32'(tx_ready),   32'd0);
        check_eq("rst_busy",       32'(busy),       32'd0);
        check_eq("rst_fault_sync", 32'(fault_sync), 32'd0);
        check_eq("rst_ready_sync", 32'(ready_sync), 32'd0);
        rst_n = 1;
        model_reset();
        model_en = 1;
        tick(3);

        // Power-up send, then back-to-back frames with tx_valid held
        send(16'hA5C3);
        tick(2);
        b2b_arm = 1;
        send(16'h0001);
        send(16'hFFFF);
        tx_valid = 0;
        tick(FrameEnd + G + 5);
        b2b_arm = 0;

        // Random words with bend_req wiggling every cycle
        rand_bend = 1;
        for (int i = 0; i < 6; i++) send(16'($urandom));
        tx_valid = 0;
        tick(FrameEnd + G + 5);
        rand_bend = 0;

        // Park deferral: park_req drops around cycle 40 of a frame
        send(16'h1234);
        tx_valid = 0;
        hs_before = hs_cnt;
        tick(39);
        park_req = 0;
        tx_data  = 16'h5555;
        tx_valid = 1;
        tick(250);
        check_eq("park_low_after", 32'(park), 32'd0);
        check_eq("no_hs_parked", 32'(hs_cnt - hs_before), 32'd0);
        tx_valid = 0;
        park_req = 1;
        tick(3);

        // Fault mid-frame: frame completes, next handshake waits for clear
        send(16'hC0DE);
        tx_valid = 0;
        tick(49);
        fault = 1;
        tick(2);
        check_eq("fault_sync_2cyc", 32'(fault_sync), 32'd1);
        tick(148);
        tx_data  = 16'h0BEE;
        tx_valid = 1;
        tick(20);
        fault = 0;
        send(16'h0BEE);
        tx_valid = 0;
        tick(FrameEnd + G + 5);

        // Reset pulsed around cycle 60 of a frame
        send(16'h3C3C);
        tx_valid = 0;
        tick(59);
        #2;
        model_en = 0;
        rst_n = 0;
        #1;
        check_eq("mid_rst_csn",     32'(csn),     32'd1);
        check_eq("mid_rst_spi_clk", 32'(spi_clk), 32'd0);
        check_eq("mid_rst_park",    32'(park),    32'd0);
        check_eq("mid_rst_busy",    32'(busy),    32'd0);
        hi = 0;
        repeat (5) begin
            @(negedge clk);
            if (spi_clk !== 1'b0) hi++;
        end
        check_eq("sclk_in_reset", 32'(hi), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
        model_en = 1;
        tick(40);

        // Recovery frame after reset
        send(16'h8001);
        tx_valid = 0;
        tick(FrameEnd + G + 5);
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
